// File: rtl/conv_pkg.sv
// Shared definitions for the activation collector: data widths, FSM state
// encoding, requantization clamp limits and the requant helper.
//   ACT_W   : accumulator width from the MAC stage
//   PIX_W   : requantized pixel width
//   state_t : collector FSM encoding
//   requant : {sat, data} = clamp(acc >>> shift)
package conv_pkg;

  localparam int ACT_W = 48;
  localparam int PIX_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam logic signed [ACT_W-1:0] SAT_MAX = 48'sd131071;
  localparam logic signed [ACT_W-1:0] SAT_MIN = -48'sd131072;

  // Arithmetic shift floors toward -inf; MSB of the result flags a clamp.
  function automatic logic [PIX_W:0] requant(input logic signed [ACT_W-1:0] acc,
                                             input int unsigned shift);
    logic signed [ACT_W-1:0] sh;
    sh = acc >>> shift;
    if (sh > SAT_MAX)
      return {1'b1, SAT_MAX[PIX_W-1:0]};
    else if (sh < SAT_MIN)
      return {1'b1, SAT_MIN[PIX_W-1:0]};
    else
      return {1'b0, sh[PIX_W-1:0]};
  endfunction

endpackage

// File: rtl/act_fifo.sv
// Output FIFO for requantized window results.
//   clk, rst : clock, async active-high reset
//   push     : write request (dropped when full unless a pop happens too)
//   wdata    : entry to write
//   pop      : read request (ignored when empty)
//   rdata    : registered head entry; holds last value when empty
//   valid    : FIFO non-empty
//   full     : level == DEPTH
//   level    : occupancy 0..DEPTH
module act_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [AW:0]      level_next;
  logic             do_push, do_pop;

  assign valid   = (level != '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign rd_next = do_pop ? rd_ptr + 1'b1 : rd_ptr;

  always_comb begin
    level_next = level;
    if (do_push && !do_pop)
      level_next = level + 1'b1;
    else if (!do_push && do_pop)
      level_next = level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

  // Head register: when the entry about to become head is the one being
  // written this cycle, bypass the memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      level  <= level_next;
      if (level_next != '0) begin
        if (level == '0 || (level == (AW+1)'(1) && do_pop))
          rdata <= wdata;
        else
          rdata <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/act_collector.sv
// Collects one activation per window of ELEMS MAC products, requantizes it
// and queues it in an output FIFO.
//   clk, rst    : clock, async active-high reset
//   mac_valid   : one MAC product accumulated this cycle
//   act_in      : signed accumulator (includes products up to last mac_valid)
//   window_done : one-cycle pulse in the capture cycle
//   out_data    : signed requantized head entry
//   out_sat     : head entry was clamped
//   out_valid   : FIFO non-empty
//   out_ready   : consumer pops head when out_valid is high
//   level       : FIFO occupancy
//   overflow    : sticky, a capture was dropped on a full FIFO
//
// state      | meaning
// IDLE       | no window in progress
// ACCUM      | counting products of the current window
// CAPTURE    | one cycle: act_in sampled, result pushed
module act_collector
  import conv_pkg::*;
#(
  parameter int ELEMS = 48,
  parameter int SHIFT = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mac_valid,
  input  logic [ACT_W-1:0]       act_in,
  output logic                   window_done,
  output logic [PIX_W-1:0]       out_data,
  output logic                   out_sat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int CNT_W = $clog2(ELEMS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ELEMS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [PIX_W:0]   cap_word;
  logic [PIX_W:0]   head;
  logic             capture;
  logic             fifo_full;

  assign capture  = (state == ST_CAPTURE);
  assign cap_word = requant($signed(act_in), SHIFT);
  assign out_sat  = head[PIX_W];
  assign out_data = head[PIX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      window_done <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      window_done <= 1'b0;
      if (capture && fifo_full && !(out_ready && out_valid))
        overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (mac_valid) begin
            state <= ST_ACCUM;
            cnt   <= CNT_W'(1);
          end
        end
        ST_ACCUM: begin
          if (mac_valid) begin
            if (cnt == LAST) begin
              state       <= ST_CAPTURE;
              cnt         <= '0;
              window_done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          // A product arriving in the capture cycle is the first of the next window.
          if (mac_valid) begin
            state <= ST_ACCUM;
            cnt   <= CNT_W'(1);
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  act_fifo #(
    .WIDTH(PIX_W + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .wdata (cap_word),
    .pop   (out_ready),
    .rdata (head),
    .valid (out_valid),
    .full  (fifo_full),
    .level (level)
  );

endmodule

// File: tb/tb_act_collector.sv
module tb_act_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        mac_valid;
  logic [47:0] act_in;
  logic        window_done;
  logic [17:0] out_data;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  level;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  act_collector #(.ELEMS(48), .SHIFT(8), .DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .mac_valid   (mac_valid),
    .act_in      (act_in),
    .window_done (window_done),
    .out_data    (out_data),
    .out_sat     (out_sat),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 48 products then one capture cycle; returns pulse count and the loop index of the first pulse.
  task automatic run_window(input logic [47:0] val, input logic rdy_cap,
                            output int pulses, output int first_idx);
    pulses = 0;
    first_idx = -1;
    for (int i = 0; i < 48; i++) begin
      mac_valid = 1'b1;
      act_in = val;
      step();
      if (window_done) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
      end
    end
    mac_valid = 1'b0;
    out_ready = rdy_cap;
    step();
    if (window_done) pulses++;
    out_ready = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic sat_case(input string tag, input logic [47:0] val,
                          input logic [17:0] exp_d, input logic exp_s);
    int p, fi;
    run_window(val, 1'b0, p, fi);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_sat"}, out_sat, exp_s);
    pop_one();
  endtask

  int p, fi;
  int pidx[$];
  logic [47:0] va, vb;

  initial begin
    rst = 1'b1;
    mac_valid = 1'b0;
    act_in = '0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_level", level, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sat", out_sat, 0);
    check("rst_wdone", window_done, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    step();

    // basic window
    run_window(48'h0000_0012_3400, 1'b0, p, fi);
    check("w1_pulses", p, 1);
    check("w1_pulse_pos", fi, 47);
    check("w1_wdone_low", window_done, 0);
    check("w1_valid", out_valid, 1);
    check("w1_level", level, 1);
    check("w1_data", out_data, 18'h01234);
    check("w1_sat", out_sat, 0);
    pop_one();
    check("pop_level", level, 0);
    check("pop_valid", out_valid, 0);
    check("hold_data", out_data, 18'h01234);
    pop_one();
    check("empty_pop_level", level, 0);

    // requant / saturation boundaries
    sat_case("pos_sat", 48'h0100_0000_0000, 18'h1FFFF, 1'b1);
    sat_case("neg_sat", 48'hFF00_0000_0000, 18'h20000, 1'b1);
    sat_case("minus1", 48'hFFFF_FFFF_FFFF, 18'h3FFFF, 1'b0);
    sat_case("max_exact", 48'h0000_01FF_FFFF, 18'h1FFFF, 1'b0);
    sat_case("max_plus1", 48'h0000_0200_0000, 18'h1FFFF, 1'b1);
    sat_case("min_exact", 48'hFFFF_FE00_0000, 18'h20000, 1'b0);

    // back-to-back windows
    va = 48'h0A00;
    vb = 48'h0B00;
    pidx.delete();
    for (int i = 0; i < 96; i++) begin
      mac_valid = 1'b1;
      act_in = (i <= 48) ? va : vb;
      step();
      if (window_done) pidx.push_back(i);
    end
    mac_valid = 1'b0;
    act_in = vb;
    step();
    if (window_done) pidx.push_back(96);
    check("b2b_pulses", pidx.size(), 2);
    if (pidx.size() == 2) begin
      check("b2b_pos0", pidx[0], 47);
      check("b2b_pos1", pidx[1], 95);
    end
    check("b2b_level", level, 2);
    check("b2b_head0", out_data, 18'h0000A);
    pop_one();
    check("b2b_head1", out_data, 18'h0000B);
    pop_one();
    check("b2b_empty", level, 0);

    // overflow: 9 windows into an 8-deep FIFO
    for (int k = 1; k <= 9; k++) run_window(48'(k) << 8, 1'b0, p, fi);
    check("ovf_level", level, 8);
    check("ovf_flag", overflow, 1);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("ovf_drain%0d", k), out_data, 18'(k));
      pop_one();
    end
    check("ovf_drained", out_valid, 0);
    check("ovf_sticky", overflow, 1);

    // reset mid-window
    run_window(48'h5500, 1'b0, p, fi);
    check("pre_rst_level", level, 1);
    for (int i = 0; i < 20; i++) begin
      mac_valid = 1'b1;
      step();
    end
    mac_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mrst_level", level, 0);
    check("mrst_valid", out_valid, 0);
    check("mrst_data", out_data, 0);
    check("mrst_sat", out_sat, 0);
    check("mrst_wdone", window_done, 0);
    check("mrst_ovf", overflow, 0);
    step();
    rst = 1'b0;
    step();
    run_window(48'h6600, 1'b0, p, fi);
    check("post_rst_pulses", p, 1);
    check("post_rst_pos", fi, 47);
    check("post_rst_level", level, 1);
    check("post_rst_data", out_data, 18'h00066);
    pop_one();

    // full FIFO with a pop in the capture cycle
    for (int k = 1; k <= 8; k++) run_window(48'(k) << 8, 1'b0, p, fi);
    check("full_level", level, 8);
    run_window(48'(9) << 8, 1'b1, p, fi);
    check("fullpop_level", level, 8);
    check("fullpop_ovf", overflow, 0);
    for (int k = 2; k <= 9; k++) begin
      check($sformatf("fullpop_drain%0d", k), out_data, 18'(k));
      pop_one();
    end
    check("fullpop_empty", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/act_collector.md
ACT_COLLECTOR -- requirements
Module: act_collector

Interface
REQ-001 Parameter ELEMS, default 48, number of MAC products per window (4 rows x 4 cols x 3 depth).
REQ-002 Parameter SHIFT, default 8, right-shift applied to the accumulator before saturation.
REQ-003 Parameter DEPTH, default 8, output FIFO entries (power of two).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 mac_valid  in  1  high for each cycle a product is accumulated by the MAC stage.
REQ-007 act_in  in  48  signed accumulator value; reflects all products up to the previous mac_valid cycle.
REQ-008 window_done  out  1  one-cycle pulse in the cycle a window result is captured.
REQ-009 out_data  out  18  signed requantized result at FIFO head.
REQ-010 out_sat  out  1  head entry was saturated.
REQ-011 out_valid  out  1  FIFO non-empty.
REQ-012 out_ready  in  1  consumer accepts head when out_valid and out_ready are both high.
REQ-013 level  out  4  FIFO occupancy, 0..DEPTH.
REQ-014 overflow  out  1  sticky; a capture was dropped because the FIFO was full.

Function
REQ-015 FSM states IDLE, ACCUM, CAPTURE; reset state IDLE.
REQ-016 IDLE: first mac_valid -> ACCUM, element counter = 1.
REQ-017 ACCUM: each mac_valid increments the counter; mac_valid at counter ELEMS-1 -> CAPTURE, counter = 0.
REQ-018 ACCUM with mac_valid low: hold state and counter (stall tolerated, no timeout).
REQ-019 CAPTURE lasts exactly one cycle: sample act_in, pulse window_done, push one entry.
REQ-020 CAPTURE with mac_valid high: counter = 1, next state ACCUM (back-to-back windows, no lost product); mac_valid low: next state IDLE.
REQ-021 Latency: result is at FIFO head (out_valid high) the cycle after CAPTURE when the FIFO was empty.
REQ-022 Requant: arithmetic shift right by SHIFT (floor), then saturate to [-131072, 131071]; out_sat = 1 iff clamped.
REQ-023 Push accepted when level < DEPTH, or when level == DEPTH and a pop occurs in the same cycle.
REQ-024 Push refused: entry dropped, overflow set, held until reset; FSM proceeds unaffected.
REQ-025 Simultaneous push and pop: level unchanged, FIFO order preserved.
REQ-026 Empty: out_valid low; out_data/out_sat hold their last value (0 after reset); pop ignored.
REQ-027 Pointers wrap modulo DEPTH; level distinguishes full from empty.

Reset
REQ-028 rst asserted at any time, including mid-window: FSM IDLE, counter 0, FIFO emptied, level 0, out_valid 0, out_data 0, out_sat 0, window_done 0, overflow 0.
REQ-029 Partial window in progress at reset is discarded; the first mac_valid after deassertion starts a new window.

Structure
REQ-030 Shared package conv_pkg holds ACT_W = 48, PIX_W = 18, the FSM state encoding and the saturation limits.
REQ-031 FIFO is one sub-module, act_fifo (width PIX_W+1, depth DEPTH, same clk/rst).

Verification
REQ-032 48 consecutive mac_valid, act_in = 0x1234_00 at capture, SHIFT=8 -> out_data = 0x1234, out_sat 0, window_done one pulse.
REQ-033 act_in = 2^40 at capture -> out_data = 131071, out_sat 1; act_in = -2^40 -> out_data = -131072, out_sat 1.
REQ-034 Two back-to-back windows (96 mac_valid, no gap) -> exactly two entries, level = 2, second window counted from its first product.
REQ-035 out_ready low, 9 windows, DEPTH=8 -> level = 8, overflow = 1, first 8 results drained in order.
REQ-036 Full FIFO with out_ready high in the capture cycle -> push accepted, level stays 8, overflow stays 0.
REQ-037 rst pulsed after 20 mac_valid -> all outputs 0; the next 48 mac_valid produce exactly one entry.
